serial_adder: RTL and testbench

Bit-serial WIDTH-bit adder that consumes the existing `half_adder` stage. Two `half_adder` instances and a carry flip-flop form one full-adder cell, which processes one operand bit per clock, LSB first. A start/busy/done handshake frames each operation. It is the first sequential arithmetic block in the design and is the consumer of the `half_adder` sum/carry outputs.

---
 rtl/serial_adder_pkg.sv | 15 +
 rtl/serial_adder_if.sv | 23 ++
 rtl/half_adder.sv | 11 +
 rtl/serial_adder.sv | 111 +++++++++++
 tb/tb_serial_adder.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder shared definitions.
// FSM state encoding and counter sizing helper.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// serial_adder start/busy/done bus.
// Master issues operands, slave returns result.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;

  modport master (
    output start, a, b,
    input  busy, done, sum, carry_out
  );

  modport slave (
    input  start, a, b,
    output busy, done, sum, carry_out
  );
endinterface

// File: rtl/half_adder.sv
// half_adder stage.
// Single-bit sum and carry of two inputs.
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b;
  assign carry = a & b;
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, LSB first.
// Two half adders plus a carry flop form the cell.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic         clk,
  input logic         rst,
  serial_adder_if.slave bus
);
  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] next_result;
  logic [CW-1:0]    cnt;
  logic             carry_q;
  logic             busy;
  logic             done;
  logic             s0;
  logic             c0;
  logic             s;
  logic             c1;

  half_adder ha0 (
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .sum   (s0),
    .carry (c0)
  );

  half_adder ha1 (
    .a     (s0),
    .b     (carry_q),
    .sum   (s),
    .carry (c1)
  );

  // New sum bit enters at the MSB; older bits move toward bit 0
  always_comb begin
    next_result = '0;
    next_result[WIDTH-1] = s;
    for (int i = 0; i < WIDTH - 1; i++)
      next_result[i] = result[i+1];
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (bus.start) next_state = RUN;
      RUN:     if (cnt == LAST) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register with registered busy/done flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state == RUN);
      done  <= (next_state == DONE);
    end
  end

  // Operand shifters, carry flop, counter and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr    <= '0;
      b_sr    <= '0;
      result  <= '0;
      cnt     <= '0;
      carry_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            a_sr    <= bus.a;
            b_sr    <= bus.b;
            carry_q <= 1'b0;
            cnt     <= '0;
          end
        end
        RUN: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          carry_q <= c0 | c1;
          result  <= next_result;
          cnt     <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.sum       = result;
  assign bus.carry_out = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed vectors for serial_adder.
// Covers WIDTH=8 and WIDTH=1 instances.
module tb_serial_adder;
  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(1)) bus1 ();

  serial_adder #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run8(input string tag,
                      input logic [7:0] a,
                      input logic [7:0] b,
                      input logic [7:0] exp_sum,
                      input logic exp_c,
                      input bit scramble);
    int cycles;
    int busy_cnt;
    bus8.a = a;
    bus8.b = b;
    bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    cycles = 1;
    busy_cnt = 0;
    while (!bus8.done && cycles < 30) begin
      if (bus8.busy) busy_cnt++;
      if (scramble) begin
        bus8.a = 8'($urandom);
        bus8.b = 8'($urandom);
      end
      tick();
      cycles++;
    end
    check({tag, " latency"}, cycles, 9);
    check({tag, " busy cycles"}, busy_cnt, 8);
    check({tag, " sum"}, {24'h0, bus8.sum}, {24'h0, exp_sum});
    check({tag, " carry"}, {31'h0, bus8.carry_out}, {31'h0, exp_c});
    check({tag, " busy at done"}, {31'h0, bus8.busy}, 0);
    tick();
    tick();
    check({tag, " done pulse"}, {31'h0, bus8.done}, 0);
    check({tag, " held"}, {23'h0, bus8.carry_out, bus8.sum},
          {23'h0, exp_c, exp_sum});
  endtask

  task automatic run1(input logic a,
                      input logic b,
                      input logic exp_sum,
                      input logic exp_c);
    int cycles;
    bus1.a = a;
    bus1.b = b;
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    cycles = 1;
    while (!bus1.done && cycles < 10) begin
      tick();
      cycles++;
    end
    check("w1 latency", cycles, 2);
    check("w1 result", {30'h0, bus1.carry_out, bus1.sum},
          {30'h0, exp_c, exp_sum});
    tick();
  endtask

  initial begin
    int first_done;
    int second_done;
    int ndone;
    logic [7:0] sum_at_first;
    logic [7:0] sum_at_second;
    logic busy10;
    logic busy11;

    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    bus8.start = 1'b0;
    bus8.a = '0;
    bus8.b = '0;
    bus1.start = 1'b0;
    bus1.a = '0;
    bus1.b = '0;

    // reset held with random inputs
    tick();
    for (int i = 0; i < 2; i++) begin
      bus8.a = 8'($urandom);
      bus8.b = 8'($urandom);
      bus8.start = 1'($urandom);
      bus1.start = 1'($urandom);
      check("reset outs", {bus8.busy, bus8.done, bus8.carry_out, bus8.sum},
            0);
      tick();
    end
    bus8.start = 1'b0;
    bus1.start = 1'b0;
    rst = 1'b0;
    tick();
    check("post reset", {bus8.busy, bus8.done, bus8.carry_out, bus8.sum}, 0);
    check("post reset w1", {bus1.busy, bus1.done, bus1.carry_out, bus1.sum},
          0);

    run8("zero", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    run8("ff+01", 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1);

    // start held for 12 cycles
    bus8.a = 8'hA5;
    bus8.b = 8'h5A;
    first_done = -1;
    second_done = -1;
    ndone = 0;
    busy10 = 1'b0;
    busy11 = 1'b0;
    sum_at_first = '0;
    sum_at_second = '0;
    for (int k = 0; k < 25; k++) begin
      bus8.start = (k < 12);
      if (bus8.done) begin
        ndone++;
        if (first_done < 0) begin
          first_done = k;
          sum_at_first = bus8.sum;
        end else begin
          second_done = k;
          sum_at_second = bus8.sum;
        end
      end
      if (k == 10) busy10 = bus8.busy;
      if (k == 11) busy11 = bus8.busy;
      tick();
    end
    bus8.start = 1'b0;
    check("hold first done", first_done, 9);
    check("hold sum", {24'h0, sum_at_first}, 32'hFF);
    check("hold idle gap", {31'h0, busy10}, 0);
    check("hold restart", {31'h0, busy11}, 1);
    check("hold second done", second_done, 19);
    check("hold second sum", {24'h0, sum_at_second}, 32'hFF);
    check("hold done count", ndone, 2);
    check("hold carry", {31'h0, bus8.carry_out}, 0);

    // reset mid-run at bit 4
    bus8.a = 8'h3C;
    bus8.b = 8'h77;
    bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    for (int i = 1; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort busy", {31'h0, bus8.busy}, 0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus8.done) ndone++;
      tick();
    end
    check("abort no done", ndone, 0);
    run8("80+80", 8'h80, 8'h80, 8'h00, 1'b1, 1'b0);
    run8("3c+77", 8'h3C, 8'h77, 8'hB3, 1'b0, 1'b0);

    // WIDTH = 1 instance
    run1(1'b0, 1'b0, 1'b0, 1'b0);
    run1(1'b1, 1'b0, 1'b1, 1'b0);
    run1(1'b0, 1'b1, 1'b1, 1'b0);
    run1(1'b1, 1'b1, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
